// File: rtl/run_ctrl_pkg.sv
// Shared types and default constants for the run-control sequencer.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } run_state_t;

  localparam logic [8:0] HALT_CODE_DEF = 9'h1FF;
  localparam int         END_ADDR_DEF  = 128;

endpackage

// File: rtl/run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; max flags the all-ones value.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q,
  output logic         max
);

  logic [W-1:0] r_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (en && !max) begin
      r_q <= r_q + W'(1);
    end
  end

  assign q   = r_q;
  assign max = &r_q;

endmodule

// File: rtl/run_ctrl.sv
// Run-control sequencer: holds the core in reset during load, runs it, and
// stops it on end address, halt instruction or cycle-budget exhaustion.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int         D         = 12,
  parameter int         END_ADDR  = END_ADDR_DEF,
  parameter logic [8:0] HALT_CODE = HALT_CODE_DEF,
  parameter int         INIT_CYC  = 2,
  parameter int         CW        = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [D-1:0]  prog_ctr,
  input  logic [8:0]    mach_code,
  output logic          core_reset,
  output logic          core_en,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [CW-1:0] cycle_cnt
);

  localparam logic [3:0]   INIT_LOAD = 4'(INIT_CYC - 1);
  localparam logic [D-1:0] END_PC    = D'(END_ADDR);

  run_state_t r_state;
  run_state_t w_state_nxt;
  logic       r_start_q;
  logic [3:0] r_init_cnt;
  logic       r_timeout;
  logic       w_start_p;
  logic       w_launch;
  logic       w_hit;
  logic       w_cnt_max;
  logic       w_in_run;

  assign w_start_p = start & ~r_start_q;
  assign w_launch  = w_start_p & ((r_state == IDLE) | (r_state == DONE));
  assign w_hit     = (prog_ctr == END_PC) | (mach_code == HALT_CODE);
  assign w_in_run  = (r_state == RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_start_q <= 1'b0;
      r_state   <= IDLE;
    end else begin
      r_start_q <= start;
      r_state   <= w_state_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start_p) w_state_nxt = INIT;
      INIT:    if (r_init_cnt == 4'd0) w_state_nxt = RUN;
      RUN:     if (w_hit || w_cnt_max) w_state_nxt = DONE;
      DONE:    if (w_start_p) w_state_nxt = INIT;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Halt wins over budget exhaustion, so timeout is only set when no hit is present.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_init_cnt <= 4'd0;
      r_timeout  <= 1'b0;
    end else if (w_launch) begin
      r_init_cnt <= INIT_LOAD;
      r_timeout  <= 1'b0;
    end else begin
      if (r_state == INIT && r_init_cnt != 4'd0) begin
        r_init_cnt <= r_init_cnt - 4'd1;
      end
      if (w_in_run && !w_hit && w_cnt_max) begin
        r_timeout <= 1'b1;
      end
    end
  end

  always_comb begin
    core_reset = 1'b1;
    core_en    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (r_state)
      IDLE: core_reset = 1'b1;
      INIT: busy = 1'b1;
      RUN: begin
        core_reset = 1'b0;
        busy       = 1'b1;
        core_en    = ~w_hit & ~w_cnt_max;
      end
      DONE: begin
        core_reset = 1'b0;
        done       = 1'b1;
      end
      default: core_reset = 1'b1;
    endcase
  end

  sat_counter #(
    .W (CW)
  ) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (w_launch),
    .en    (core_en),
    .q     (cycle_cnt),
    .max   (w_cnt_max)
  );

  assign timeout = r_timeout;

endmodule
